// File: rtl/mem_wb_stage.sv
// MEM stage of the pipeline: resolves branches, runs loads/stores against a
// variable-latency req/ready data memory, and holds the MEM/WB pipeline register.
module mem_wb_stage #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_MemtoReg,
    input  logic        ex_mem_MemRead,
    input  logic        ex_mem_MemWrite,
    input  logic        ex_mem_Branch,
    input  logic        ex_mem_RegWrite,
    input  logic [31:0] pc_out,
    input  logic        out_zero,
    input  logic [31:0] alu_resultaddress,
    input  logic [31:0] writedata,
    input  logic [4:0]  ex_rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        mem_stall,
    output logic        pcsrc,
    output logic [31:0] branch_target,
    output logic        mem_fault,
    output logic        mem_wb_MemtoReg,
    output logic        mem_wb_RegWrite,
    output logic [31:0] mem_wb_readdata,
    output logic [31:0] mem_wb_alu_result,
    output logic [4:0]  mem_wb_rd
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        fault_q;
    logic        mwb_mtr_q;
    logic        mwb_rw_q;
    logic [31:0] mwb_rdata_q;
    logic [31:0] mwb_alu_q;
    logic [4:0]  mwb_rd_q;

    logic access_s;
    logic misaligned_s;
    logic start_s;
    logic timeout_s;

    assign access_s     = ex_mem_MemRead | ex_mem_MemWrite;
    assign misaligned_s = access_s & (alu_resultaddress[1:0] != 2'b00);
    assign start_s      = (state_q == IDLE) & access_s & ~misaligned_s;
    // Ready has priority over timeout, so timeout only fires while ready is low.
    assign timeout_s    = (state_q == BUSY) & ~dmem_ready & (cnt_q == LAST_CNT);

    assign mem_stall     = start_s | ((state_q == BUSY) & ~dmem_ready & ~timeout_s);
    assign pcsrc         = ex_mem_Branch & out_zero & (state_q == IDLE);
    assign branch_target = pc_out;

    assign dmem_req   = (state_q == BUSY);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign mem_fault  = fault_q;

    assign mem_wb_MemtoReg   = mwb_mtr_q;
    assign mem_wb_RegWrite   = mwb_rw_q;
    assign mem_wb_readdata   = mwb_rdata_q;
    assign mem_wb_alu_result = mwb_alu_q;
    assign mem_wb_rd         = mwb_rd_q;

    // Access FSM, captured request fields, fault flag and MEM/WB register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            we_q        <= 1'b0;
            fault_q     <= 1'b0;
            mwb_mtr_q   <= 1'b0;
            mwb_rw_q    <= 1'b0;
            mwb_rdata_q <= 32'd0;
            mwb_alu_q   <= 32'd0;
            mwb_rd_q    <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_s) begin
                        addr_q  <= alu_resultaddress;
                        we_q    <= ex_mem_MemWrite;
                        wdata_q <= writedata;
                        cnt_q   <= 8'd0;
                        state_q <= BUSY;
                    end else if (misaligned_s) begin
                        fault_q     <= 1'b1;
                        mwb_mtr_q   <= 1'b0;
                        mwb_rw_q    <= 1'b0;
                        mwb_rdata_q <= 32'd0;
                        mwb_alu_q   <= 32'd0;
                        mwb_rd_q    <= 5'd0;
                    end else begin
                        mwb_mtr_q   <= ex_mem_MemtoReg;
                        mwb_rw_q    <= ex_mem_RegWrite;
                        mwb_rdata_q <= 32'd0;
                        mwb_alu_q   <= alu_resultaddress;
                        mwb_rd_q    <= ex_rd;
                    end
                end
                BUSY: begin
                    if (dmem_ready) begin
                        mwb_mtr_q   <= ex_mem_MemtoReg;
                        mwb_rw_q    <= ex_mem_RegWrite;
                        mwb_rdata_q <= we_q ? 32'd0 : dmem_rdata;
                        mwb_alu_q   <= alu_resultaddress;
                        mwb_rd_q    <= ex_rd;
                        state_q     <= IDLE;
                    end else if (timeout_s) begin
                        fault_q     <= 1'b1;
                        mwb_mtr_q   <= 1'b0;
                        mwb_rw_q    <= 1'b0;
                        mwb_rdata_q <= 32'd0;
                        mwb_alu_q   <= 32'd0;
                        mwb_rd_q    <= 5'd0;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed plan steps followed by random
// instructions checked against a transaction-level model with a word memory.
module tb_mem_wb_stage;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_mem_MemtoReg = 1'b0, ex_mem_MemRead = 1'b0, ex_mem_MemWrite = 1'b0;
    logic        ex_mem_Branch = 1'b0, ex_mem_RegWrite = 1'b0, out_zero = 1'b0;
    logic [31:0] pc_out = 32'd0, alu_resultaddress = 32'd0, writedata = 32'd0;
    logic [4:0]  ex_rd = 5'd0;
    logic        dmem_req, dmem_we, mem_stall, pcsrc, mem_fault;
    logic [31:0] dmem_addr, dmem_wdata, branch_target;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_ready = 1'b0;
    logic        mem_wb_MemtoReg, mem_wb_RegWrite;
    logic [31:0] mem_wb_readdata, mem_wb_alu_result;
    logic [4:0]  mem_wb_rd;

    int checks = 0;
    int errors = 0;

    // Reference state: what the writeback side should show, plus the memory image.
    logic        m_mtr = 1'b0, m_rw = 1'b0, m_fault = 1'b0, m_we = 1'b0;
    logic [31:0] m_rdata = 32'd0, m_alu = 32'd0, m_addr = 32'd0, m_wd = 32'd0;
    logic [4:0]  m_rd = 5'd0;
    logic [31:0] mem [logic [31:0]];

    mem_wb_stage #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .ex_mem_MemtoReg(ex_mem_MemtoReg), .ex_mem_MemRead(ex_mem_MemRead),
        .ex_mem_MemWrite(ex_mem_MemWrite), .ex_mem_Branch(ex_mem_Branch),
        .ex_mem_RegWrite(ex_mem_RegWrite), .pc_out(pc_out), .out_zero(out_zero),
        .alu_resultaddress(alu_resultaddress), .writedata(writedata), .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .mem_stall(mem_stall), .pcsrc(pcsrc), .branch_target(branch_target),
        .mem_fault(mem_fault), .mem_wb_MemtoReg(mem_wb_MemtoReg),
        .mem_wb_RegWrite(mem_wb_RegWrite), .mem_wb_readdata(mem_wb_readdata),
        .mem_wb_alu_result(mem_wb_alu_result), .mem_wb_rd(mem_wb_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string tag);
        chk({tag, ".MemtoReg"}, {31'd0, mem_wb_MemtoReg}, {31'd0, m_mtr});
        chk({tag, ".RegWrite"}, {31'd0, mem_wb_RegWrite}, {31'd0, m_rw});
        chk({tag, ".readdata"}, mem_wb_readdata, m_rdata);
        chk({tag, ".alu"}, mem_wb_alu_result, m_alu);
        chk({tag, ".rd"}, {27'd0, mem_wb_rd}, {27'd0, m_rd});
        chk({tag, ".fault"}, {31'd0, mem_fault}, {31'd0, m_fault});
    endtask

    task automatic model_bubble();
        m_mtr = 1'b0; m_rw = 1'b0; m_rdata = 32'd0; m_alu = 32'd0; m_rd = 5'd0;
        m_fault = 1'b1;
    endtask

    task automatic model_reset();
        m_mtr = 1'b0; m_rw = 1'b0; m_rdata = 32'd0; m_alu = 32'd0; m_rd = 5'd0;
        m_fault = 1'b0; m_we = 1'b0; m_addr = 32'd0; m_wd = 32'd0;
    endtask

    // One instruction through MEM; lat = BUSY cycles with ready low before ready rises.
    task automatic run_instr(input string tag, input logic mtr, input logic mr,
                             input logic mw, input logic br, input logic rw,
                             input logic [31:0] pc, input logic z,
                             input logic [31:0] alu, input logic [31:0] wd,
                             input logic [4:0] rd, input int lat);
        logic acc, mis, rdy, last;
        ex_mem_MemtoReg = mtr; ex_mem_MemRead = mr; ex_mem_MemWrite = mw;
        ex_mem_Branch = br; ex_mem_RegWrite = rw; pc_out = pc; out_zero = z;
        alu_resultaddress = alu; writedata = wd; ex_rd = rd;
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
        #1;
        acc = mr | mw;
        mis = acc && (alu[1:0] != 2'b00);
        chk({tag, ".pcsrc"}, {31'd0, pcsrc}, {31'd0, br & z});
        chk({tag, ".target"}, branch_target, pc);
        chk({tag, ".req_idle"}, {31'd0, dmem_req}, 32'd0);
        chk({tag, ".addr_hold"}, dmem_addr, m_addr);
        chk({tag, ".we_hold"}, {31'd0, dmem_we}, {31'd0, m_we});
        chk({tag, ".stall_idle"}, {31'd0, mem_stall}, {31'd0, acc & ~mis});
        if (!acc || mis) begin
            tick();
            if (mis) begin
                model_bubble();
            end else begin
                m_mtr = mtr; m_rw = rw; m_rdata = 32'd0; m_alu = alu; m_rd = rd;
            end
        end else begin
            tick();
            m_addr = alu; m_we = mw; m_wd = wd;
            rdy = 1'b0;
            for (int k = 0; k < 64; k++) begin
                rdy = (k == lat);
                dmem_ready = rdy;
                if (!mw && !mem.exists(alu)) mem[alu] = $urandom;
                dmem_rdata = (rdy && !mw) ? mem[alu] : $urandom;
                #1;
                last = rdy || (k == MW - 1);
                chk({tag, ".req"}, {31'd0, dmem_req}, 32'd1);
                chk({tag, ".addr"}, dmem_addr, alu);
                chk({tag, ".we"}, {31'd0, dmem_we}, {31'd0, mw});
                if (mw) chk({tag, ".wdata"}, dmem_wdata, wd);
                chk({tag, ".stall_busy"}, {31'd0, mem_stall}, {31'd0, ~last});
                chk({tag, ".pcsrc_busy"}, {31'd0, pcsrc}, 32'd0);
                tick();
                if (last) break;
            end
            dmem_ready = 1'b0;
            if (rdy) begin
                if (mw) mem[alu] = wd;
                m_mtr = mtr; m_rw = rw; m_alu = alu; m_rd = rd;
                m_rdata = mw ? 32'd0 : mem[alu];
            end else begin
                model_bubble();
            end
        end
        chk_wb(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] a;
        logic mr, mw, br;
        // Reset state
        tick();
        tick();
        chk("rst.req", {31'd0, dmem_req}, 32'd0);
        chk("rst.stall", {31'd0, mem_stall}, 32'd0);
        chk("rst.addr", dmem_addr, 32'd0);
        chk("rst.wdata", dmem_wdata, 32'd0);
        chk("rst.we", {31'd0, dmem_we}, 32'd0);
        chk_wb("rst");
        rst = 1'b0;

        // Directed plan steps
        run_instr("rtype", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0000_00AA, 32'h0, 5'd5, 0);
        mem[32'h100] = 32'hDEAD_BEEF;
        run_instr("load3", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h100, 32'h0, 5'd7, 2);
        chk("load3.rdata", mem_wb_readdata, 32'hDEAD_BEEF);
        run_instr("store", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h40, 32'h1234, 5'd3, 0);
        run_instr("both", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h44, 32'h55AA, 5'd4, 1);
        run_instr("ready_edge", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h44, 32'h0, 5'd9, MW - 1);
        run_instr("misalign", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h102, 32'h0, 5'd8, 0);
        run_instr("after_mis", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h33, 32'h0, 5'd2, 0);
        do_reset();
        run_instr("timeout", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h80, 32'h0, 5'd6, 99);
        run_instr("post_to", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h77, 32'h0, 5'd1, 0);
        run_instr("br_take", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 1'b1, 32'h0, 32'h0, 5'd0, 0);
        run_instr("br_not", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0, 32'h0, 5'd0, 0);
        run_instr("pre_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h5A5A, 32'h0, 5'd11, 0);

        // Reset during the 2nd BUSY cycle aborts the load
        ex_mem_MemRead = 1'b1; ex_mem_MemtoReg = 1'b1; ex_mem_RegWrite = 1'b1;
        alu_resultaddress = 32'h120; ex_rd = 5'd12; dmem_ready = 1'b0;
        tick();
        tick();
        chk("rstbusy.req2", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        ex_mem_MemRead = 1'b0; ex_mem_MemtoReg = 1'b0; ex_mem_RegWrite = 1'b0;
        alu_resultaddress = 32'h0; ex_rd = 5'd0; dmem_ready = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rstbusy.req", {31'd0, dmem_req}, 32'd0);
        chk("rstbusy.addr", dmem_addr, 32'd0);
        chk_wb("rstbusy");
        tick();
        dmem_ready = 1'b0;
        chk_wb("rstbusy.late_ready");

        // Random instructions against the model
        for (int i = 0; i < 150; i++) begin
            if (i == 75) do_reset();
            mr = 1'($urandom_range(0, 1));
            mw = ($urandom_range(0, 2) == 0);
            br = (!mr && !mw) ? 1'($urandom_range(0, 1)) : 1'b0;
            a = {24'd0, 6'($urandom), 2'b00};
            if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
            run_instr("rand", 1'($urandom), mr, mw, br, 1'($urandom), $urandom,
                      1'($urandom), a, $urandom, 5'($urandom), int'($urandom_range(0, 5)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
